packet_checker: RTL and testbench

Receive-side counterpart of the switch bench packet generator: an AXI-Stream sink that accepts frames from a switch egress port, applies a programmable backpressure pattern, and checks each frame's Ethernet/VLAN header, length, payload pattern and tuser destination port against parameters. It sits on every switch output in the self-learning benches. It exposes sticky error flags, packet and error counters, and a done/pass verdict once the expected packet count has arrived.

---
 rtl/packet_checker_pkg.sv | 31 +++
 rtl/packet_checker_tkeep_popcount.sv | 18 +
 rtl/packet_checker.sv | 231 +++++++++++++++++++++++
 tb/tb_packet_checker.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_checker_pkg.sv
// packet_checker_pkg: shared types and constants for the packet checker.
// Holds the FSM state enum, header byte offsets and the per-frame error bundle.
package packet_checker_pkg;

    typedef enum logic [1:0] {
        S_HDR,
        S_BODY,
        S_DONE
    } state_t;

    localparam int MAX_PACKET_LENGTH = 1542;

    localparam int HDR_DST  = 0;
    localparam int HDR_SRC  = 6;
    localparam int HDR_TYPE = 12;
    localparam int HDR_TCI  = 14;

    localparam logic [15:0] VLAN_TPID = 16'h8100;

    typedef struct packed {
        logic hdr;
        logic len;
        logic pay;
        logic port;
    } err_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/packet_checker_tkeep_popcount.sv
// tkeep_popcount: combinational population count of an AXI-Stream tkeep mask.
// Ports: tkeep (mask in), count (number of set bits out).
module tkeep_popcount #(
    parameter int KEEP_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(KEEP_WIDTH) + 1
) (
    input  logic [KEEP_WIDTH-1:0] tkeep,
    output logic [CNT_WIDTH-1:0]  count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            count = count + CNT_WIDTH'(tkeep[i]);
        end
    end

endmodule

// File: rtl/packet_checker.sv
// packet_checker: AXI-Stream sink that checks header, length, tuser port and
// (with PKT_CHECKER_PAYLOAD_CHECK_EN) payload of each frame; applies a rotating
// tready pattern and reports sticky flags, counters and a done/pass verdict.
// Ports: axis_aclk/axis_resetn (sync active-low), m_axis_* sink, pkt_count,
// err_count, hdr_err, len_err, payload_err, port_err, timeout, done, pass.
module packet_checker
    import packet_checker_pkg::*;
#(
    parameter int          AXIS_DATA_WIDTH   = 256,
    parameter int          AXIS_TUSER_WIDTH  = 128,
    parameter logic [47:0] EXP_DST_MAC       = 48'h1111_1111_1111,
    parameter logic [47:0] EXP_SRC_MAC       = 48'h2222_2222_2222,
    parameter logic        EXP_VLAN          = 1'b1,
    parameter logic [15:0] EXP_TYPE          = 16'h0800,
    parameter logic [2:0]  EXP_PRI           = 3'b111,
    parameter logic [7:0]  EXP_TUSER_DST     = 8'h00,
    parameter int          EXP_PACKET_LENGTH = 70,
    parameter int          EXP_PACKET_COUNT  = 10,
    parameter logic [15:0] READY_PATTERN     = 16'hFFFF,
    parameter int          TIMEOUT_CYCLES    = 4000
) (
    input  logic                          axis_aclk,
    input  logic                          axis_resetn,
    input  logic [AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    input  logic [AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    input  logic                          m_axis_tvalid,
    output logic                          m_axis_tready,
    input  logic                          m_axis_tlast,
    output logic [15:0]                   pkt_count,
    output logic [15:0]                   err_count,
    output logic                          hdr_err,
    output logic                          len_err,
    output logic                          payload_err,
    output logic                          port_err,
    output logic                          timeout,
    output logic                          done,
    output logic                          pass
);

    localparam int          KW      = AXIS_DATA_WIDTH / 8;
    localparam int          CW      = $clog2(KW) + 1;
    localparam logic [15:0] EXP_LEN = 16'(EXP_PACKET_LENGTH);
    localparam logic [15:0] MAX_LEN = 16'(MAX_PACKET_LENGTH);
    localparam logic [15:0] EXP_CNT = 16'(EXP_PACKET_COUNT);
    localparam logic [31:0] TO_LIM  = 32'(TIMEOUT_CYCLES);

    state_t       state_q, state_d;
    logic         sof_q, sof_d;
    logic [15:0]  offset_q, offset_d;
    logic [3:0]   ptr_q, ptr_d;
    logic         tready_q, tready_d;
    err_t         ferr_q, ferr_d;
    err_t         sticky_q, sticky_d;
    logic [15:0]  pkt_q, pkt_d;
    logic [15:0]  errc_q, errc_d;
    logic [31:0]  idle_q, idle_d;
    logic         timeout_q, timeout_d;
    logic         done_q, done_d;
    logic         pass_q, pass_d;

    logic [CW-1:0] beat_len;
    logic          accept;
    logic [15:0]   base;
    logic [16:0]   sum;
    logic [15:0]   new_off;
    logic [47:0]   dst, src;
    logic [15:0]   etype;
    logic [2:0]    pcp;
    logic          hdr_bad, port_bad, pay_bad;
    err_t          beat_err, cur_err;
    logic          unused_user;

    tkeep_popcount #(
        .KEEP_WIDTH (KW),
        .CNT_WIDTH  (CW)
    ) u_popcount (
        .tkeep (m_axis_tkeep),
        .count (beat_len)
    );

    assign accept  = m_axis_tvalid && tready_q;
    // A new frame restarts the offset at zero regardless of the stale register.
    assign base    = sof_q ? 16'd0 : offset_q;
    assign sum     = {1'b0, base} + 17'(beat_len);
    assign new_off = sum[16] ? 16'hFFFF : sum[15:0];

    always_comb begin
        dst = '0;
        src = '0;
        for (int j = 0; j < 6; j++) begin
            dst[8*(5-j) +: 8] = m_axis_tdata[8*(HDR_DST+j) +: 8];
            src[8*(5-j) +: 8] = m_axis_tdata[8*(HDR_SRC+j) +: 8];
        end
    end

    assign etype = {m_axis_tdata[8*HDR_TYPE +: 8],
                    m_axis_tdata[8*(HDR_TYPE+1) +: 8]};
    assign pcp   = m_axis_tdata[8*HDR_TCI+5 +: 3];

    always_comb begin
        hdr_bad = (dst != EXP_DST_MAC) || (src != EXP_SRC_MAC);
        if (EXP_VLAN) begin
            hdr_bad = hdr_bad || (etype != VLAN_TPID) || (pcp != EXP_PRI);
        end else begin
            hdr_bad = hdr_bad || (etype != EXP_TYPE);
        end
    end

    assign port_bad = (EXP_TUSER_DST != 8'h00) &&
                      (m_axis_tuser[31:24] != EXP_TUSER_DST);

    assign unused_user = ^{m_axis_tuser[AXIS_TUSER_WIDTH-1:32],
                           m_axis_tuser[23:0]};

`ifdef PKT_CHECKER_PAYLOAD_CHECK_EN
    localparam logic [15:0] HDR_END = EXP_VLAN ? 16'd16 : 16'd14;

    always_comb begin
        logic [15:0] pos;
        pay_bad = 1'b0;
        pos     = '0;
        for (int j = 0; j < KW; j++) begin
            pos = base + 16'(j);
            if ((CW'(j) < beat_len) && (pos >= HDR_END) &&
                (m_axis_tdata[8*j +: 8] != pos[7:0])) begin
                pay_bad = 1'b1;
            end
        end
    end
`else
    logic unused_data;

    assign pay_bad     = 1'b0;
    assign unused_data = ^{m_axis_tdata[AXIS_DATA_WIDTH-1:8*HDR_TCI+8],
                           m_axis_tdata[8*HDR_TCI +: 5]};
`endif

    always_comb begin
        beat_err      = '0;
        beat_err.hdr  = sof_q && hdr_bad;
        beat_err.port = sof_q && port_bad;
        beat_err.pay  = pay_bad;
        // Oversize frames are flagged as soon as they overrun, not at tlast.
        beat_err.len  = m_axis_tlast ? (new_off != EXP_LEN)
                                     : (new_off > MAX_LEN);
        cur_err       = sof_q ? err_t'('0) : ferr_q;
    end

    always_comb begin
        state_d   = state_q;
        sof_d     = sof_q;
        offset_d  = offset_q;
        ferr_d    = ferr_q;
        sticky_d  = sticky_q;
        pkt_d     = pkt_q;
        errc_d    = errc_q;
        idle_d    = idle_q;
        ptr_d     = ptr_q + 4'd1;
        tready_d  = READY_PATTERN[ptr_q];

        if (accept) begin
            sof_d    = m_axis_tlast;
            offset_d = new_off;
            ferr_d   = cur_err | beat_err;
            sticky_d = sticky_q | beat_err;
            idle_d   = '0;
            state_d  = m_axis_tlast ? S_HDR : S_BODY;
            if (m_axis_tlast) begin
                pkt_d = sat_inc16(pkt_q);
                if (|(cur_err | beat_err)) begin
                    errc_d = sat_inc16(errc_q);
                end
            end
        end else if (state_q != S_DONE && idle_q < TO_LIM) begin
            idle_d = idle_q + 32'd1;
        end

        if (done_q) begin
            state_d = S_DONE;
        end

        timeout_d = timeout_q || ((TO_LIM != 0) && (idle_d == TO_LIM));
        done_d    = pkt_q >= EXP_CNT;
        pass_d    = done_d && !(|sticky_q) && !timeout_q;
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            state_q   <= S_HDR;
            sof_q     <= 1'b1;
            offset_q  <= '0;
            ptr_q     <= '0;
            tready_q  <= 1'b0;
            ferr_q    <= '0;
            sticky_q  <= '0;
            pkt_q     <= '0;
            errc_q    <= '0;
            idle_q    <= '0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sof_q     <= sof_d;
            offset_q  <= offset_d;
            ptr_q     <= ptr_d;
            tready_q  <= tready_d;
            ferr_q    <= ferr_d;
            sticky_q  <= sticky_d;
            pkt_q     <= pkt_d;
            errc_q    <= errc_d;
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    assign m_axis_tready = tready_q;
    assign pkt_count     = pkt_q;
    assign err_count     = errc_q;
    assign hdr_err       = sticky_q.hdr;
    assign len_err       = sticky_q.len;
    assign payload_err   = sticky_q.pay;
    assign port_err      = sticky_q.port;
    assign timeout       = timeout_q;
    assign done          = done_q;
    assign pass          = pass_q;

endmodule

// File: tb/tb_packet_checker.sv
// tb_packet_checker: randomized scoreboard bench for packet_checker.
// Frames are modelled as byte arrays; a monitor compares counters and flags.
module tb_packet_checker;

    localparam logic [15:0] PAT  = 16'h5555;
    localparam logic [7:0]  TDST = 8'h04;
    localparam int          TO   = 100;
    localparam logic [47:0] DST  = 48'h1111_1111_1111;
    localparam logic [47:0] SRC  = 48'h2222_2222_2222;
    localparam logic [2:0]  PRI  = 3'b111;
    localparam int          ELEN = 70;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [255:0] tdata = '0;
    logic [31:0]  tkeep = '0;
    logic [127:0] tuser = '0;
    logic         tvalid = 1'b0;
    logic         tready;
    logic         tlast = 1'b0;
    logic [15:0]  pkt_count, err_count;
    logic         hdr_err, len_err, payload_err, port_err;
    logic         timeout, done, pass;

    always #5 clk = ~clk;

    packet_checker #(
        .EXP_TUSER_DST  (TDST),
        .READY_PATTERN  (PAT),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .axis_aclk     (clk),
        .axis_resetn   (resetn),
        .m_axis_tdata  (tdata),
        .m_axis_tkeep  (tkeep),
        .m_axis_tuser  (tuser),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .pkt_count     (pkt_count),
        .err_count     (err_count),
        .hdr_err       (hdr_err),
        .len_err       (len_err),
        .payload_err   (payload_err),
        .port_err      (port_err),
        .timeout       (timeout),
        .done          (done),
        .pass          (pass)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         pkt;
        int         err;
        logic [3:0] fl;
    } exp_t;

    exp_t       sb[$];
    int         m_pkt = 0;
    int         m_err = 0;
    logic [3:0] m_fl = '0;

    logic [7:0]   fr[2048];
    int           flen;
    logic [127:0] fuser;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Reference rules applied to the whole frame: {hdr, len, pay, port}.
    function automatic logic [3:0] frame_errs();
        logic       h = 1'b0;
        logic       l;
        logic       p = 1'b0;
        logic       u;
        logic [47:0] d = DST;
        logic [47:0] s = SRC;
        for (int j = 0; j < 6; j++) begin
            if (fr[j] != d[47-8*j -: 8]) h = 1'b1;
            if (fr[6+j] != s[47-8*j -: 8]) h = 1'b1;
        end
        if (fr[12] != 8'h81 || fr[13] != 8'h00 || fr[14][7:5] != PRI)
            h = 1'b1;
        l = (flen != ELEN);
`ifdef PKT_CHECKER_PAYLOAD_CHECK_EN
        for (int i = 16; i < flen; i++) begin
            if (fr[i] != 8'(i)) p = 1'b1;
        end
`endif
        u = (fuser[31:24] != TDST);
        return {h, l, p, u};
    endfunction

    task automatic make_good(input int len);
        logic [47:0] d = DST;
        logic [47:0] s = SRC;
        flen = len;
        for (int i = 0; i < len; i++) fr[i] = 8'(i);
        for (int j = 0; j < 6; j++) begin
            fr[j]   = d[47-8*j -: 8];
            fr[6+j] = s[47-8*j -: 8];
        end
        fr[12] = 8'h81;
        fr[13] = 8'h00;
        fr[14] = {PRI, 5'($urandom)};
        fr[15] = 8'($urandom);
        fuser  = {$urandom, $urandom, $urandom, $urandom};
        fuser[31:24] = TDST;
    endtask

    task automatic push_expect();
        logic [3:0] e;
        e = frame_errs();
        m_pkt++;
        if (|e) m_err++;
        m_fl = m_fl | e;
        sb.push_back('{m_pkt, m_err, m_fl});
    endtask

    task automatic send_frame(input int abort_at, input bit long_chk);
        int i = 0;
        int beat = 0;
        int n;
        int wc;
        int gap;
        bit last_b;
        bit lchk = 1'b0;
        while (i < flen) begin
            if (abort_at > 0 && beat == abort_at) begin
                tvalid = 1'b0;
                return;
            end
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                tvalid = 1'b0;
                @(negedge clk);
            end
            n = (beat == 0) ? ((flen < 32) ? flen : 32)
                            : int'($urandom_range(1, 32));
            if (n > flen - i) n = flen - i;
            last_b = (i + n == flen);
            for (int k = 0; k < 8; k++) tdata[32*k +: 32] = $urandom;
            tkeep = '0;
            for (int j = 0; j < n; j++) begin
                tdata[8*j +: 8] = fr[i+j];
                tkeep[j] = 1'b1;
            end
            tuser  = fuser;
            tlast  = last_b;
            tvalid = 1'b1;
            if (last_b) push_expect();
            wc = 0;
            while (!tready && wc < 100) begin
                @(negedge clk);
                wc++;
            end
            if (!tready) begin
                chk("handshake_tready", 32'(tready), 32'd1);
                tvalid = 1'b0;
                return;
            end
            @(negedge clk);
            i += n;
            beat++;
            if (long_chk && !lchk && !last_b && i > 1542) begin
                chk("len_err_early", 32'(len_err), 32'd1);
                lchk = 1'b1;
            end
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        tvalid = 1'b0;
        tlast  = 1'b0;
        @(negedge clk);
        chk("rst_pkt_count", 32'(pkt_count), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_flags", 32'({hdr_err, len_err, payload_err, port_err,
                              timeout}), 32'd0);
        chk("rst_done_pass", 32'({done, pass}), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        chk("sb_empty_at_reset", 32'(sb.size()), 32'd0);
        sb.delete();
        m_pkt = 0;
        m_err = 0;
        m_fl  = '0;
    endtask

    logic       rst_seen = 1'b0;
    logic [3:0] rp = '0;
    logic [15:0] pat_v = PAT;
    logic [15:0] prev_pkt = '0;

    always @(posedge clk) rst_seen = resetn;

    always @(negedge clk) begin
        exp_t e;
        logic exp_tr;
        if (!rst_seen) begin
            rp     = '0;
            exp_tr = 1'b0;
        end else begin
            exp_tr = pat_v[rp];
            rp     = rp + 4'd1;
        end
        chk("tready_pattern", 32'(tready), 32'(exp_tr));
        if (rst_seen && pkt_count != prev_pkt) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_frame", 32'(pkt_count), 32'(prev_pkt));
            end else begin
                e = sb.pop_front();
                chk("pkt_count", 32'(pkt_count), 32'(e.pkt));
                chk("err_count", 32'(err_count), 32'(e.err));
                chk("sticky_flags",
                    32'({hdr_err, len_err, payload_err, port_err}),
                    32'(e.fl));
            end
        end
        prev_pkt = pkt_count;
    end

    initial begin
        int k;
        int len;
        do_reset();

        for (int f = 0; f < 10; f++) begin
            make_good(ELEN);
            send_frame(0, 1'b0);
        end
        repeat (3) @(negedge clk);
        chk("done_after_10", 32'(done), 32'd1);
        chk("pass_after_10", 32'(pass), 32'd1);

        make_good(ELEN); fr[14] = 8'h40; send_frame(0, 1'b0);
        make_good(ELEN); send_frame(0, 1'b0);
        make_good(69); send_frame(0, 1'b0);
        make_good(ELEN); fr[40] = 8'h00; send_frame(0, 1'b0);
        make_good(ELEN); fuser[31:24] = 8'h02; send_frame(0, 1'b0);

        for (int f = 0; f < 30; f++) begin
            k   = $urandom_range(0, 7);
            len = (k == 2) ? int'($urandom_range(16, 200)) : ELEN;
            make_good(len);
            case (k)
                1: fr[14][7:5] = 3'($urandom);
                3: fr[$urandom_range(16, len-1)] = 8'($urandom);
                4: fuser[31:24] = 8'($urandom);
                5: fr[$urandom_range(0, 11)] ^= 8'h01;
                6: fr[12] = 8'h08;
                default: ;
            endcase
            send_frame(0, 1'b0);
        end
        repeat (3) @(negedge clk);
        chk("done_after_random", 32'(done), 32'(m_pkt >= 10));
        chk("pass_after_random", 32'(pass), 32'(m_pkt >= 10 && m_fl == 0));

        do_reset();
        make_good(2000);
        send_frame(0, 1'b1);
        make_good(ELEN); send_frame(0, 1'b0);
        make_good(ELEN); send_frame(0, 1'b0);

        make_good(ELEN);
        send_frame(2, 1'b0);
        do_reset();
        make_good(ELEN);
        send_frame(0, 1'b0);
        repeat (3) @(negedge clk);
        chk("after_midreset_done", 32'(done), 32'd0);

        do_reset();
        repeat (TO - 1) @(negedge clk);
        chk("timeout_before", 32'(timeout), 32'd0);
        @(negedge clk);
        chk("timeout_reached", 32'(timeout), 32'd1);
        repeat (2) @(negedge clk);
        chk("timeout_pass", 32'(pass), 32'd0);
        chk("sb_empty_end", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
